// File: rtl/food_pkg.sv
// Shared types and constants for the snake food/score manager.
package food_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_CHECK,
    S_STEP,
    S_COMMIT
  } fsm_state_e;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_HEIGHT = 24;
  localparam int unsigned CELLS      = DEF_WIDTH * DEF_HEIGHT;

  // Feedback taps 16,14,13,11 of a right-shifting Fibonacci LFSR (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/food_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the food placement random source.
module food_lfsr16
  import food_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/food_manager.sv
// Per-channel food/score manager: eat detection, saturating scores and
// sequential rejection-sampled food regeneration.
module food_manager
  import food_pkg::*;
#(
  parameter int unsigned N_SNAKES  = 2,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned HEIGHT    = 24,
  parameter int unsigned NUM_LEN   = 10,
  parameter int unsigned SCORE_W   = 4,
  parameter int unsigned MAX_TRIES = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_step,
  input  logic [N_SNAKES*NUM_LEN-1:0]   i_heads,
  output logic [N_SNAKES*NUM_LEN-1:0]   o_foods,
  output logic [N_SNAKES-1:0]           o_food_valid,
  output logic [N_SNAKES*SCORE_W-1:0]   o_scores,
  output logic [N_SNAKES-1:0]           o_eaten,
  output logic                          o_busy
);

  localparam int unsigned NCELLS = WIDTH * HEIGHT;
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned K_W    = (N_SNAKES > 1) ? $clog2(N_SNAKES) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [NUM_LEN:0]   CELLS_X   = (NUM_LEN+1)'(NCELLS);

  fsm_state_e          r_state, w_state_nxt;
  logic [TRY_W-1:0]    r_tries, w_tries_nxt;
  logic [K_W-1:0]      r_k, w_k_nxt, w_first_k;
  logic [NUM_LEN-1:0]  r_cand, w_cand_nxt, w_fallback, w_cand_inc;

  logic [NUM_LEN-1:0]  r_foods  [N_SNAKES];
  logic [SCORE_W-1:0]  r_scores [N_SNAKES];
  logic [NUM_LEN-1:0]  w_heads  [N_SNAKES];

  logic [N_SNAKES-1:0] r_valid, r_pending, r_eaten;
  logic [N_SNAKES-1:0] w_eat, w_occ, w_commit, w_pending_nxt;
  logic                r_busy, w_busy_nxt, w_reject, w_out_of_field;

  logic [15:0]         w_lfsr;
  logic                w_lfsr_unused;

  food_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_lfsr (w_lfsr)
  );

  assign w_lfsr_unused = ^w_lfsr[15:NUM_LEN];

  function automatic logic [NUM_LEN-1:0] wrap_inc(input logic [NUM_LEN-1:0] c);
    logic [NUM_LEN:0] s;
    s = {1'b0, c} + (NUM_LEN+1)'(1);
    return (s >= CELLS_X) ? '0 : s[NUM_LEN-1:0];
  endfunction

  // Per-channel unpack, eat detection and occupancy compare against the candidate.
  for (genvar gi = 0; gi < N_SNAKES; gi++) begin : g_chan
    assign w_heads[gi] = i_heads[gi*NUM_LEN +: NUM_LEN];
    assign w_eat[gi]   = i_step && r_valid[gi] && (w_heads[gi] == r_foods[gi]);
    assign w_occ[gi]   = (r_cand == w_heads[gi]) ||
                         (r_valid[gi] && (K_W'(gi) != r_k) && (r_cand == r_foods[gi]));
    assign o_foods[gi*NUM_LEN +: NUM_LEN]  = r_foods[gi];
    assign o_scores[gi*SCORE_W +: SCORE_W] = r_scores[gi];
  end

  assign w_out_of_field = ({1'b0, r_cand} >= CELLS_X);
  assign w_reject       = w_out_of_field || (|w_occ);
  assign w_fallback     = wrap_inc(r_foods[r_k]);
  assign w_cand_inc     = wrap_inc(r_cand);

  always_comb begin
    w_first_k = '0;
    for (int i = int'(N_SNAKES) - 1; i >= 0; i--) begin
      if (r_pending[i]) w_first_k = K_W'(i);
    end
  end

  // Next-state logic for the regeneration engine.
  always_comb begin
    w_state_nxt = r_state;
    w_tries_nxt = r_tries;
    w_cand_nxt  = r_cand;
    w_k_nxt     = r_k;
    w_commit    = '0;
    unique case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_k_nxt     = w_first_k;
          w_tries_nxt = '0;
          w_state_nxt = S_DRAW;
        end
      end
      S_DRAW: begin
        w_cand_nxt  = w_lfsr[NUM_LEN-1:0];
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!w_reject) begin
          w_state_nxt = S_COMMIT;
        end else if (r_tries < TRY_W'(MAX_TRIES - 1)) begin
          w_tries_nxt = r_tries + TRY_W'(1);
          w_state_nxt = S_DRAW;
        end else begin
          w_cand_nxt  = w_fallback;
          w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        if (!w_reject) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_cand_nxt = w_cand_inc;
        end
      end
      S_COMMIT: begin
        w_commit    = N_SNAKES'(1) << r_k;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pending_nxt = (r_pending | w_eat) & ~w_commit;
  assign w_busy_nxt    = (|w_pending_nxt) || (w_state_nxt != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_tries <= '0;
      r_k     <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tries <= w_tries_nxt;
      r_k     <= w_k_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  // Channel datapath: scores saturate, eats invalidate food until the commit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
      r_valid   <= '1;
      r_eaten   <= '0;
      r_busy    <= 1'b0;
      for (int i = 0; i < N_SNAKES; i++) begin
        r_foods[i]  <= NUM_LEN'((i + 1) * WIDTH + WIDTH / 2);
        r_scores[i] <= '0;
      end
    end else begin
      r_pending <= w_pending_nxt;
      r_valid   <= (r_valid & ~w_eat) | w_commit;
      r_eaten   <= w_eat;
      r_busy    <= w_busy_nxt;
      for (int i = 0; i < N_SNAKES; i++) begin
        if (w_commit[i]) r_foods[i] <= r_cand;
        if (w_eat[i] && (r_scores[i] != SCORE_MAX)) r_scores[i] <= r_scores[i] + SCORE_W'(1);
      end
    end
  end

  assign o_food_valid = r_valid;
  assign o_eaten      = r_eaten;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_food_manager.sv
// Scoreboard bench for food_manager: a 2-channel 32x24 instance and a 1-channel 2x2 instance.
module tb_food_manager;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, step;
  logic [9:0]  h0, h1;
  logic [19:0] heads, foods;
  logic [1:0]  fvalid, eaten;
  logic [7:0]  scores;
  logic        busy;

  assign heads = {h1, h0};

  logic        rst_s, step_s;
  logic [1:0]  head_s, food_s;
  logic        fv_s, eaten_s, busy_s;
  logic [3:0]  score_s;

  food_manager #(
    .N_SNAKES(2), .WIDTH(32), .HEIGHT(24), .NUM_LEN(10),
    .SCORE_W(4), .MAX_TRIES(16), .LFSR_SEED(16'hACE1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_step(step), .i_heads(heads),
    .o_foods(foods), .o_food_valid(fvalid), .o_scores(scores),
    .o_eaten(eaten), .o_busy(busy)
  );

  food_manager #(
    .N_SNAKES(1), .WIDTH(2), .HEIGHT(2), .NUM_LEN(2),
    .SCORE_W(4), .MAX_TRIES(2), .LFSR_SEED(16'hACE1)
  ) dut_s (
    .i_clk(clk), .i_rst(rst_s), .i_step(step_s), .i_heads(head_s),
    .o_foods(food_s), .o_food_valid(fv_s), .o_scores(score_s),
    .o_eaten(eaten_s), .o_busy(busy_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0] eaten;
    logic [7:0] scores;
  } eat_exp_t;

  eat_exp_t eat_q[$];
  int       commit_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference LFSR for the small instance (taps 16,14,13,11, right shift).
  logic [15:0] m_s;
  always @(posedge clk) begin
    if (rst_s) m_s <= 16'hACE1;
    else       m_s <= {m_s[0] ^ m_s[2] ^ m_s[3] ^ m_s[5], m_s[15:1]};
  end

  // Eat monitor: every eaten pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst && eaten != 2'b00) begin
      eat_exp_t e;
      if (eat_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL eat_unexpected: got eaten=%b expected none", eaten);
      end else begin
        e = eat_q.pop_front();
        check("eat_mask", 32'(eaten), 32'(e.eaten));
        check("eat_scores", 32'(scores), 32'(e.scores));
      end
    end
  end

  // Commit monitor: a food_valid rising edge is a commit; check order and legality.
  logic [1:0] prev_v;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && fvalid[i] && !prev_v[i]) begin
        logic [9:0] f, o;
        f = foods[i*10 +: 10];
        o = foods[(1-i)*10 +: 10];
        if (commit_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL commit_unexpected: got channel %0d expected none", i);
        end else begin
          check("commit_chan", 32'(i), 32'(commit_q.pop_front()));
        end
        check("food_in_field", 32'(f < 10'd768), 32'd1);
        check("food_not_head", 32'((f != h0) && (f != h1)), 32'd1);
        if (fvalid[1-i]) check("food_not_other", 32'(f != o), 32'd1);
      end
    end
    prev_v = fvalid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got busy=1 after %0d cycles expected idle", name, n);
    end
    tick();
  endtask

  // Small instance: force both random draws onto the head so the linear fallback runs.
  task automatic small_regen(input logic [1:0] food_now, input bit reset_in_step);
    logic [1:0] a;
    head_s = food_now;
    step_s = 1'b1;
    tick();
    step_s = 1'b0;
    check("s_eaten", 32'(eaten_s), 32'd1);
    check("s_valid_drop", 32'(fv_s), 32'd0);
    tick();
    a = m_s[1:0];
    tick();
    head_s = a;
    tick();
    a = m_s[1:0];
    tick();
    head_s = a;
    tick();
    head_s = 2'd2;
    if (reset_in_step) begin
      rst_s = 1'b1;
      tick();
      rst_s = 1'b0;
      check("s_rst_food", 32'(food_s), 32'd3);
      check("s_rst_score", 32'(score_s), 32'd0);
      check("s_rst_busy", 32'(busy_s), 32'd0);
      check("s_rst_valid", 32'(fv_s), 32'd1);
    end else begin
      tick();
      check("s_commit_busy", 32'(busy_s), 32'd1);
      tick();
      check("s_fallback_food", 32'(food_s), 32'd0);
      check("s_fallback_valid", 32'(fv_s), 32'd1);
      check("s_score", 32'(score_s), 32'd1);
      check("s_idle", 32'(busy_s), 32'd0);
    end
  endtask

  initial begin
    int sat;
    rst = 1'b1; step = 1'b0; h0 = 10'd6; h1 = 10'd5;
    rst_s = 1'b1; step_s = 1'b0; head_s = 2'd1;
    tick();
    tick();
    rst = 1'b0;
    rst_s = 1'b0;

    check("rst_foods", 32'(foods), 32'({10'd80, 10'd48}));
    check("rst_scores", 32'(scores), 32'd0);
    check("rst_valid", 32'(fvalid), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_eaten", 32'(eaten), 32'd0);
    check("s_init_food", 32'(food_s), 32'd3);

    // Single eat on channel 0.
    h0 = 10'd48;
    eat_q.push_back('{eaten: 2'b01, scores: 8'h01});
    commit_q.push_back(0);
    do_step();
    check("t1_valid", 32'(fvalid), 32'd2);
    check("t1_busy", 32'(busy), 32'd1);
    wait_idle("t1");
    check("t1_valid_back", 32'(fvalid), 32'd3);
    check("t1_food1_kept", 32'(foods[19:10]), 32'd80);

    // Both channels eat in the same step.
    do_reset();
    h0 = 10'd48; h1 = 10'd80;
    eat_q.push_back('{eaten: 2'b11, scores: 8'h11});
    commit_q.push_back(0);
    commit_q.push_back(1);
    do_step();
    wait_idle("t2");
    check("t2_valid", 32'(fvalid), 32'd3);
    check("t2_distinct", 32'(foods[9:0] != foods[19:10]), 32'd1);

    // Head on the other channel's food is ignored.
    do_reset();
    h0 = 10'd6; h1 = 10'd48;
    do_step();
    check("t3_eaten", 32'(eaten), 32'd0);
    check("t3_scores", 32'(scores), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_valid", 32'(fvalid), 32'd3);

    // Sixteen eats on channel 0: score saturates at 15, food still regenerated.
    h1 = 10'd5;
    for (int k = 1; k <= 16; k++) begin
      h0 = foods[9:0];
      sat = (k > 15) ? 15 : k;
      eat_q.push_back('{eaten: 2'b01, scores: 8'(sat)});
      commit_q.push_back(0);
      do_step();
      wait_idle("t4");
    end
    check("t4_sat_score", 32'(scores), 32'h0F);
    check("t4_valid", 32'(fvalid), 32'd3);

    // Small field: fallback path, then reset while stepping.
    small_regen(2'd3, 1'b0);
    small_regen(2'd0, 1'b1);

    tick();
    check("queues_drained", 32'(eat_q.size() + commit_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
